load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_BYTES, 1024, size of the byte-addressable data memory; any access touching a byte at or above it faults.
REQ-002 The clock and reset ports SHALL be: one clock; reset is asynchronous and active-low, with ports clk, rst_n.
REQ-003 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  32  byte address, any alignment.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_fault  out  1  illegal funct3 or out-of-range access.
- mem_write  out  1  memory write strobe.
- mem_addr  out  32  word-aligned memory address.
- mem_write_data  out  32  lane-aligned store data.
- mem_byte_enable  out  4  per-lane write enable.
- mem_read_data  in  32  combinational memory read word, valid when mem_write=0.

Function
REQ-004 Legal funct3 values SHALL be: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU with req_store=1 and all other codes fault.
REQ-005 FSM states SHALL be IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE.
REQ-006 IDLE: on req_valid&&req_ready, register the request; faulting request -> RESP, else -> ACC0.
REQ-007 Access size n is 1, 2 or 4 bytes; off = addr[1:0]; an access crosses a word when off+n>4.
REQ-008 ACC0: mem_addr={addr[31:2],2'b00}; enables = lanes off..min(3,off+n-1); store data = (zero-extended wdata << 8*off)[31:0]; loads capture mem_read_data as lo word.
REQ-009 ACC1 (crossing only): mem_addr = ACC0 address + 4; enables = remaining low lanes; store data = (wdata << 8*off)[63:32]; loads capture hi word.
REQ-010 mem_write SHALL be 1 only in ACC0/ACC1 for stores, exactly one cycle per state.
REQ-011 Load result = ({hi,lo} >> 8*off), truncated to n bytes, sign-extended for B/H and zero-extended for BU/HU.
REQ-012 Fault: any byte in addr..addr+n-1 >= MEM_BYTES (32-bit wrap counts as fault) -> no memory cycle, resp_fault=1, resp_rdata=0.
REQ-013 RESP: resp_valid=1 with stable rdata/fault until resp_ready=1, then IDLE; no request accepted in that same cycle.
REQ-014 Latency from accept edge T: aligned resp_valid at T+2, crossing T+3, fault T+1.
REQ-015 Outside ACC0/ACC1, mem_write, mem_addr, mem_write_data, mem_byte_enable SHALL be 0.

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_fault=0, all mem_* outputs 0.
REQ-017 Reset during ACC1 SHALL abandon the access without response; a completed ACC0 store half is not rolled back.

Structure
REQ-018 Package lsu_pkg SHALL hold the funct3 enum, FSM state enum and size/offset helper constants.
REQ-019 One combinational sub-module lsu_align SHALL compute lane enables, store shifting and load extraction/extension.

Verification
REQ-020 SW 0x10, data 0xDEADBEEF -> one cycle mem_write=1, mem_addr 0x10, be 1111, data 0xDEADBEEF; resp_valid at T+2, fault 0.
REQ-021 Word 0x10 holds 0x80112233; LB 0x13 -> mem_addr 0x10, rdata 0xFFFFFF80; LBU 0x13 -> 0x00000080.
REQ-022 SH 0x0F data 0x1234 -> ACC0 addr 0x0C be 1000 data 0x34000000; ACC1 addr 0x10 be 0001 data 0x00000012; resp T+3.
REQ-023 LW 0x3FE (MEM_BYTES 1024) -> no memory cycle, resp at T+1, fault 1, rdata 0; funct3 011 -> same.
REQ-024 Reset asserted in ACC1 of crossing store -> mem_write 0 immediately, no resp_valid, req_ready 1 after release.
REQ-025 resp_ready held 0 for 3 cycles -> resp_valid/rdata stable, req_ready 0, IDLE entered the cycle after resp_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// request payload and access-size/offset helpers.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NLANES = 4;
    localparam int unsigned OFF_W  = 2;
    localparam int unsigned SIZE_W = 3;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic            store;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Access size in bytes; only meaningful for legal codes.
    function automatic logic [SIZE_W-1:0] access_bytes(input logic [2:0] funct3);
        logic [SIZE_W-1:0] n;
        case (funct3[1:0])
            2'b00:   n = SIZE_W'(1);
            2'b01:   n = SIZE_W'(2);
            default: n = SIZE_W'(4);
        endcase
        return n;
    endfunction

    function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
        logic legal;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !store;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic crosses_word(input logic [OFF_W-1:0] off,
                                          input logic [SIZE_W-1:0] nbytes);
        return (SIZE_W'(off) + nbytes) > SIZE_W'(NLANES);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store shifting for both word
// halves of an access, plus load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [OFF_W-1:0]  off,
    input  logic [SIZE_W-1:0] nbytes,
    input  logic              sign_ext,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   lo_word,
    input  logic [XLEN-1:0]   hi_word,
    output logic [NLANES-1:0] be_lo_c,
    output logic [NLANES-1:0] be_hi_c,
    output logic [XLEN-1:0]   wdata_lo_c,
    output logic [XLEN-1:0]   wdata_hi_c,
    output logic [XLEN-1:0]   rdata_c
);

    logic [2*NLANES-1:0] size_mask;
    logic [2*NLANES-1:0] lane_mask;
    logic [2*XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]     rdata_sh;
    logic [4:0]          bit_sh;

    assign bit_sh = {off, 3'b000};

    always_comb begin
        size_mask = 8'b0000_1111;
        case (nbytes)
            3'd1:    size_mask = 8'b0000_0001;
            3'd2:    size_mask = 8'b0000_0011;
            default: size_mask = 8'b0000_1111;
        endcase
    end

    // Lanes past byte 3 spill into the following word.
    assign lane_mask  = size_mask << off;
    assign be_lo_c    = lane_mask[NLANES-1:0];
    assign be_hi_c    = lane_mask[2*NLANES-1:NLANES];

    assign wdata_sh   = {{XLEN{1'b0}}, wdata} << bit_sh;
    assign wdata_lo_c = wdata_sh[XLEN-1:0];
    assign wdata_hi_c = wdata_sh[2*XLEN-1:XLEN];

    assign rdata_sh   = XLEN'({hi_word, lo_word} >> bit_sh);

    always_comb begin
        rdata_c = rdata_sh;
        case (nbytes)
            3'd1:    rdata_c = sign_ext ? {{24{rdata_sh[7]}}, rdata_sh[7:0]}
                                        : {24'd0, rdata_sh[7:0]};
            3'd2:    rdata_c = sign_ext ? {{16{rdata_sh[15]}}, rdata_sh[15:0]}
                                        : {16'd0, rdata_sh[15:0]};
            default: rdata_c = rdata_sh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, misaligned accesses split
// into two word cycles, range/funct3 faults answered without a memory cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_write_data,
    output logic [NLANES-1:0] mem_byte_enable,
    input  logic [XLEN-1:0]   mem_read_data
);

    localparam int unsigned AW = XLEN + 1;

    state_e            state_q, state_d;
    lsu_req_t          req_q, req_in, req_nxt;
    logic [XLEN-1:0]   lo_q;
    logic              accept_c, req_fault_c, cross_c;
    logic [AW-1:0]     last_byte_c;

    logic [NLANES-1:0] be_lo_c, be_hi_c;
    logic [XLEN-1:0]   wdata_lo_c, wdata_hi_c, rdata_c;

    logic              req_ready_d, resp_valid_d, resp_fault_d, mem_write_d;
    logic [XLEN-1:0]   resp_rdata_d, mem_addr_d, mem_write_data_d;
    logic [NLANES-1:0] mem_byte_enable_d;

    assign req_in = '{store: req_store, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
    assign accept_c = (state_q == IDLE) && req_valid;
    assign req_nxt  = accept_c ? req_in : req_q;

    // 33-bit end address so a 32-bit wrap also lands above MEM_BYTES.
    assign last_byte_c = {1'b0, req_in.addr} + AW'(access_bytes(req_in.funct3)) - AW'(1);
    assign req_fault_c = !funct3_legal(req_in.store, req_in.funct3)
                      || (last_byte_c >= AW'(MEM_BYTES));
    assign cross_c     = crosses_word(req_q.addr[OFF_W-1:0], access_bytes(req_q.funct3));

    lsu_align u_align (
        .off        (req_nxt.addr[OFF_W-1:0]),
        .nbytes     (access_bytes(req_nxt.funct3)),
        .sign_ext   (!req_nxt.funct3[2]),
        .wdata      (req_nxt.wdata),
        .lo_word    ((state_q == ACC0) ? mem_read_data : lo_q),
        .hi_word    (mem_read_data),
        .be_lo_c    (be_lo_c),
        .be_hi_c    (be_hi_c),
        .wdata_lo_c (wdata_lo_c),
        .wdata_hi_c (wdata_hi_c),
        .rdata_c    (rdata_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_fault_c ? RESP : ACC0;
            ACC0:    state_d = cross_c ? ACC1 : RESP;
            ACC1:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        req_ready_d       = 1'b0;
        resp_valid_d      = 1'b0;
        resp_fault_d      = 1'b0;
        resp_rdata_d      = '0;
        mem_write_d       = 1'b0;
        mem_addr_d        = '0;
        mem_write_data_d  = '0;
        mem_byte_enable_d = '0;
        case (state_d)
            IDLE: req_ready_d = 1'b1;
            ACC0: begin
                mem_write_d       = req_nxt.store;
                mem_addr_d        = {req_nxt.addr[XLEN-1:2], 2'b00};
                mem_write_data_d  = wdata_lo_c;
                mem_byte_enable_d = be_lo_c;
            end
            ACC1: begin
                mem_write_d       = req_nxt.store;
                mem_addr_d        = {req_nxt.addr[XLEN-1:2], 2'b00} + XLEN'(NLANES);
                mem_write_data_d  = wdata_hi_c;
                mem_byte_enable_d = be_hi_c;
            end
            RESP: begin
                resp_valid_d = 1'b1;
                if (state_q == RESP) begin
                    resp_fault_d = resp_fault;
                    resp_rdata_d = resp_rdata;
                end else if (state_q == IDLE) begin
                    resp_fault_d = 1'b1;
                end else if (!req_nxt.store) begin
                    resp_rdata_d = rdata_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_fault      <= 1'b0;
            resp_rdata      <= '0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_write_data  <= '0;
            mem_byte_enable <= '0;
        end else begin
            req_ready       <= req_ready_d;
            resp_valid      <= resp_valid_d;
            resp_fault      <= resp_fault_d;
            resp_rdata      <= resp_rdata_d;
            mem_write       <= mem_write_d;
            mem_addr        <= mem_addr_d;
            mem_write_data  <= mem_write_data_d;
            mem_byte_enable <= mem_byte_enable_d;
        end
    end

    // Request is held for the whole access; low word kept for split loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            lo_q  <= '0;
        end else begin
            if (accept_c)          req_q <= req_in;
            if (state_q == ACC0)   lo_q  <= mem_read_data;
        end
    end

endmodule
